// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - funct codes and FSM state type shared by alu_mc and its multiply/divide unit
package alu_mc_pkg;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_BEQ   = 6'b111000;
    localparam logic [5:0] F_BNE   = 6'b111001;
    localparam logic [5:0] F_BLEZ  = 6'b111010;
    localparam logic [5:0] F_BGTZ  = 6'b111011;
    localparam logic [5:0] F_BGEZ  = 6'b111100;
    localparam logic [5:0] F_LUI   = 6'b111101;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/alu_mc_muldiv.sv
// rtl/alu_mc_muldiv.sv - iterative radix-2 shift-add multiplier / restoring divider on magnitudes
module alu_mc_muldiv
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH);

    logic             active;
    logic             div_mode;
    logic             neg_q;
    logic             neg_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic             add_cin;
    logic [WIDTH+1:0] sum;

    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;

    // One adder serves both: product accumulate, or trial subtract (carry out = no borrow).
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (div_mode) begin
            add_a   = {acc_hi, acc_lo[WIDTH-1]};
            add_b   = ~{1'b0, opnd};
            add_cin = 1'b1;
        end else begin
            add_a = {1'b0, acc_hi};
            add_b = acc_lo[0] ? {1'b0, opnd} : '0;
        end
    end

    assign sum  = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH + 1){1'b0}}, add_cin};
    assign done = active && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
        end else if (start) begin
            active   <= 1'b1;
            div_mode <= is_div;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= is_div ? mag_a : mag_b;
            opnd     <= is_div ? mag_b : mag_a;
            neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= is_signed && is_div && a[WIDTH-1];
        end else if (active) begin
            cnt <= cnt + CW'(1);
            if (done) begin
                active <= 1'b0;
            end
            if (div_mode) begin
                acc_hi <= sum[WIDTH+1] ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], sum[WIDTH+1]};
            end else begin
                acc_hi <= sum[WIDTH:1];
                acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Divide by zero leaves the dividend magnitude in acc_hi, so only the quotient is forced.
    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = (opnd == '0) ? '1 : (neg_q ? -acc_lo : acc_lo);
    assign rem_fix  = neg_r ? -acc_hi : acc_hi;
    assign res_hi   = div_mode ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = div_mode ? quo_fix : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - handshaked EX-stage ALU with multicycle MULT/DIV and HI/LO; option ALU_MC_OVF_TRAP_EN
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
`ifdef ALU_MC_OVF_TRAP_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam logic [WIDTH-1:0] LUI_MASK = WIDTH'(32'hFFFF_FFFF);

    state_t           state;
    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             is_signed;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_hi;
    logic [WIDTH-1:0] mdu_lo;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (func == F_MULT) || (func == F_MULTU);
    assign is_div    = (func == F_DIV) || (func == F_DIVU);
    assign is_signed = (func == F_MULT) || (func == F_DIV);

    alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && (is_mul || is_div)),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (op_a),
        .b         (op_b),
        .done      (mdu_done),
        .res_hi    (mdu_hi),
        .res_lo    (mdu_lo)
    );

    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] sc_result;
    logic             sc_zero;
    logic             is_branch;
    logic             br_cond;

    assign add_res = op_a + op_b;
    assign sub_res = op_a - op_b;

`ifdef ALU_MC_OVF_TRAP_EN
    logic sc_ovf;
    logic ovf_add;
    logic ovf_sub;

    assign ovf_add = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_res[WIDTH-1] != op_a[WIDTH-1]);
    assign ovf_sub = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_res[WIDTH-1] != op_a[WIDTH-1]);
    assign sc_ovf  = ((func == F_ADD) && ovf_add) || ((func == F_SUB) && ovf_sub);
`endif

    always_comb begin
        sc_result = '0;
        is_branch = 1'b0;
        br_cond   = 1'b0;
        case (func)
            F_SLL:          sc_result = op_b << shamt;
            F_SRL:          sc_result = op_b >> shamt;
            F_SRA:          sc_result = $signed(op_b) >>> shamt;
            F_SLLV:         sc_result = op_b << op_a[SHW-1:0];
            F_SRLV:         sc_result = op_b >> op_a[SHW-1:0];
            F_SRAV:         sc_result = $signed(op_b) >>> op_a[SHW-1:0];
            F_MFHI:         sc_result = hi;
            F_MFLO:         sc_result = lo;
            F_ADD, F_ADDU:  sc_result = add_res;
            F_SUB, F_SUBU:  sc_result = sub_res;
            F_AND:          sc_result = op_a & op_b;
            F_OR:           sc_result = op_a | op_b;
            F_XOR:          sc_result = op_a ^ op_b;
            F_NOR:          sc_result = ~(op_a | op_b);
            F_SLT:          sc_result = {{(WIDTH - 1){1'b0}}, $signed(op_a) < $signed(op_b)};
            F_SLTU:         sc_result = {{(WIDTH - 1){1'b0}}, op_a < op_b};
            F_LUI:          sc_result = (op_b << 16) & LUI_MASK;
            F_BEQ: begin
                is_branch = 1'b1;
                br_cond   = (op_a == op_b);
            end
            F_BNE: begin
                is_branch = 1'b1;
                br_cond   = (op_a != op_b);
            end
            F_BLEZ: begin
                is_branch = 1'b1;
                br_cond   = op_a[WIDTH-1] || (op_a == '0);
            end
            F_BGTZ: begin
                is_branch = 1'b1;
                br_cond   = !op_a[WIDTH-1] && (op_a != '0);
            end
            F_BGEZ: begin
                is_branch = 1'b1;
                br_cond   = !op_a[WIDTH-1];
            end
            default:        sc_result = '0;
        endcase
    end

    // Unknown codes fall out as result=0, which makes zero=1 without a special case.
    assign sc_zero = is_branch ? br_cond : (sc_result == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            result    <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
`ifdef ALU_MC_OVF_TRAP_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef ALU_MC_OVF_TRAP_EN
            ovf       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= MUL;
                        end else if (is_div) begin
                            state <= DIV;
                        end else begin
                            result    <= sc_result;
                            zero      <= sc_zero;
                            out_valid <= 1'b1;
`ifdef ALU_MC_OVF_TRAP_EN
                            ovf       <= sc_ovf;
`endif
                        end
                    end
                end
                MUL, DIV: begin
                    if (mdu_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hi        <= mdu_hi;
                    lo        <= mdu_lo;
                    result    <= mdu_lo;
                    zero      <= (mdu_lo == '0);
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed and random checks of alu_mc against a behavioural ISA-level model
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
`ifdef ALU_MC_OVF_TRAP_EN
    logic        ovf;
`endif

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .hi        (hi),
        .lo        (lo),
`ifdef ALU_MC_OVF_TRAP_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] obs_r;
    logic        obs_z;
    logic        obs_v;

    logic [5:0] codes [26] = '{
        6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
        6'b010000, 6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011,
        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
        6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b111000, 6'b111001,
        6'b111010, 6'b111011
    };

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ISA-level reference: plain arithmetic on 32/64-bit values, HI/LO kept as architectural state.
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic z,
                         output logic v, output bit md);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        longint             p;
        longint unsigned    pu;
        bit                 br;
        bit                 cond;
        sa = a; sb = b; r = '0; v = 1'b0; md = 0; br = 0; cond = 0;
        case (f)
            6'b000000: r = b << sh;
            6'b000010: r = b >> sh;
            6'b000011: r = sb >>> sh;
            6'b000100: r = b << a[4:0];
            6'b000110: r = b >> a[4:0];
            6'b000111: r = sb >>> a[4:0];
            6'b010000: r = m_hi;
            6'b010010: r = m_lo;
            6'b011000: begin p = longint'(sa) * longint'(sb); {m_hi, m_lo} = p; md = 1; end
            6'b011001: begin pu = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = pu; md = 1; end
            6'b011010: begin
                md = 1;
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
                else begin m_lo = sa / sb; m_hi = sa % sb; end
            end
            6'b011011: begin
                md = 1;
                if (b == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
            6'b100000: begin
                r = a + b;
`ifdef ALU_MC_OVF_TRAP_EN
                p = longint'(sa) + longint'(sb);
                v = (p > 64'sd2147483647) || (p < -64'sd2147483648);
`endif
            end
            6'b100001: r = a + b;
            6'b100010: begin
                r = a - b;
`ifdef ALU_MC_OVF_TRAP_EN
                p = longint'(sa) - longint'(sb);
                v = (p > 64'sd2147483647) || (p < -64'sd2147483648);
`endif
            end
            6'b100011: r = a - b;
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = ~(a | b);
            6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
            6'b101011: r = (a < b) ? 32'd1 : 32'd0;
            6'b111000: begin br = 1; cond = (a == b); end
            6'b111001: begin br = 1; cond = (a != b); end
            6'b111010: begin br = 1; cond = (sa <= 0); end
            6'b111011: begin br = 1; cond = (sa > 0); end
            6'b111100: begin br = 1; cond = (sa >= 0); end
            6'b111101: r = {b[15:0], 16'h0000};
            default:   r = '0;
        endcase
        if (md) r = m_lo;
        z = br ? cond : (r == 0);
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
        logic [31:0] er;
        logic        ez;
        logic        ev;
        bit          md;
        int          n;
        int          stall;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_op", 64'(in_ready), 64'(1));
        model(f, a, b, sh, er, ez, ev, md);
        func = f; op_a = a; op_b = b; shamt = sh; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        stall = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (in_ready !== 1'b1) stall++;
            @(posedge clk);
            #1;
            n++;
        end
        obs_r = result;
        obs_z = zero;
        obs_v = 1'b0;
`ifdef ALU_MC_OVF_TRAP_EN
        obs_v = ovf;
        check($sformatf("ovf f=%b", f), 64'(obs_v), 64'(ev));
`endif
        check($sformatf("latency f=%b", f), 64'(n), md ? 64'(34) : 64'(1));
        check($sformatf("stall f=%b", f), 64'(stall), md ? 64'(33) : 64'(0));
        check($sformatf("result f=%b a=%h b=%h", f, a, b), 64'(obs_r), 64'(er));
        check($sformatf("zero f=%b", f), 64'(obs_z), 64'(ez));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
        @(posedge clk);
        #1;
        check("out_valid_pulse", 64'(out_valid), 64'(0));
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'($urandom_range(0, 15));
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        logic [5:0] f;
        rst = 1'b1; in_valid = 1'b0; func = '0; op_a = '0; op_b = '0; shamt = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", 64'(result), 64'(0));
        check("rst_zero", 64'(zero), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef ALU_MC_OVF_TRAP_EN
        check("rst_ovf", 64'(ovf), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op(6'b100010, 32'd5, 32'd7, 5'd0);
        check("sub_5_7", 64'(obs_r), 64'hFFFF_FFFE);
        run_op(6'b101010, 32'd5, 32'd7, 5'd0);
        check("slt_5_7", 64'(obs_r), 64'd1);

        run_op(6'b011000, 32'hFFFF_FFFD, 32'd7, 5'd0);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(6'b010000, 32'd0, 32'd0, 5'd0);
        check("mfhi", 64'(obs_r), 64'hFFFF_FFFF);

        run_op(6'b011011, 32'd100, 32'd7, 5'd0);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);
        run_op(6'b011010, -32'sd7, 32'd2, 5'd0);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
        run_op(6'b011010, 32'd9, 32'd0, 5'd0);
        check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        check("div0_hi", 64'(hi), 64'd9);
        run_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        check("divmin_lo", 64'(lo), 64'h8000_0000);
        check("divmin_hi", 64'(hi), 64'd0);
        run_op(6'b011010, -32'sd9, 32'd0, 5'd0);
        run_op(6'b011000, 32'h8000_0000, 32'h8000_0000, 5'd0);

        run_op(6'b111100, 32'h8000_0000, 32'd0, 5'd0);
        check("bgez_min", 64'(obs_z), 64'd0);
        run_op(6'b111000, 32'h1234, 32'h1234, 5'd0);
        check("beq_zero", 64'(obs_z), 64'd1);
        check("beq_result", 64'(obs_r), 64'd0);
        run_op(6'b100001, 32'd1, 32'd1, 5'd0);
        check("addu_after_beq", 64'(obs_z), 64'd0);
        run_op(6'b111110, 32'd3, 32'd4, 5'd0);
        check("unknown_zero", 64'(obs_z), 64'd1);
        run_op(6'b111101, 32'd0, 32'hABCD_1234, 5'd0);
        run_op(6'b000011, 32'd0, 32'h8000_00F0, 5'd4);
        run_op(6'b000111, 32'd35, 32'h8000_00F0, 5'd0);

        // Abort a MULTU with reset after 10 cycles of iteration.
        @(negedge clk);
        func = 6'b011001; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        check("abort_no_out_valid", 64'(seen), 64'(0));
        run_op(6'b011001, 32'd6, 32'd7, 5'd0);

`ifdef ALU_MC_OVF_TRAP_EN
        run_op(6'b100000, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check("add_ovf_result", 64'(obs_r), 64'h8000_0000);
        check("add_ovf_flag", 64'(obs_v), 64'd1);
        run_op(6'b100001, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check("addu_no_ovf", 64'(obs_v), 64'd0);
        run_op(6'b100010, 32'h8000_0000, 32'd1, 5'd0);
`endif

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) f = 6'($urandom);
            else f = codes[$urandom_range(0, 25)];
            run_op(f, rnd_op(), rnd_op(), 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
